// File: rtl/gowin_sp_param_if.sv
// Access bus for the parametrised single-port RAM.
// The RAM takes the slave side of this bus.
interface gowin_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int LANE_W = 8
);
    localparam int NL = DATA_W / LANE_W;

    logic              ce;
    logic              oce;
    logic              wre;
    logic [NL-1:0]     be;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_vld;
    logic              busy;

    modport master (
        output ce, oce, wre, be, ad, din,
        input  dout, rd_vld, busy
    );

    modport slave (
        input  ce, oce, wre, be, ad, din,
        output dout, rd_vld, busy
    );
endinterface

// File: rtl/gowin_sp_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable read latency,
// selectable write mode, a read-valid strobe and a post-reset clear engine.
module gowin_sp_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int LANE_W     = 8,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0,
    parameter int CLEAR_INIT = 1
) (
    input logic             clk,
    input logic             reset,
    gowin_sp_param_if.slave bus
);
    localparam int NL    = DATA_W / LANE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] s1_q, s1_d;
    logic              s1_vld_q, s1_vld_d;
    logic              access;
    logic              wr_en;
    logic              clear_we;

    // Clear engine: one zero write per cycle, leaving CLEAR right after the last word.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_we = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign access  = bus.ce && (state_q == ST_READY);
    assign wr_en   = access && bus.wre;
    assign rd_word = mem[bus.ad];

    always_comb begin
        merged_word = rd_word;
        for (int i = 0; i < NL; i++) begin
            if (bus.be[i]) begin
                merged_word[i*LANE_W +: LANE_W] = bus.din[i*LANE_W +: LANE_W];
            end
        end
    end

    // Stage-1 register: what a write places here depends on the write mode.
    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = 1'b0;
        if (access) begin
            if (!bus.wre) begin
                s1_d     = rd_word;
                s1_vld_d = 1'b1;
            end else if (WRITE_MODE == 1) begin
                s1_d     = merged_word;
                s1_vld_d = 1'b1;
            end else if (WRITE_MODE == 2) begin
                s1_d     = rd_word;
                s1_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (CLEAR_INIT != 0) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_READY;
            end
            cnt_q    <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
        end
    end

    // The array itself is never reset so it stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.be[i]) begin
                    mem[bus.ad][i*LANE_W +: LANE_W] <= bus.din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign bus.busy = (state_q == ST_CLEAR);

    generate
        if (READ_MODE == 1) begin : g_pipe
            logic [DATA_W-1:0] dout_q, dout_d;
            logic              rd_vld_q, rd_vld_d;

            // With oce low the output holds and any pending stage-1 result is simply lost.
            always_comb begin
                dout_d   = dout_q;
                rd_vld_d = 1'b0;
                if (bus.oce) begin
                    dout_d   = s1_q;
                    rd_vld_d = s1_vld_q;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q   <= '0;
                    rd_vld_q <= 1'b0;
                end else begin
                    dout_q   <= dout_d;
                    rd_vld_q <= rd_vld_d;
                end
            end

            assign bus.dout   = dout_q;
            assign bus.rd_vld = rd_vld_q;
        end else begin : g_bypass
            logic unused_oce;

            assign unused_oce = bus.oce;
            assign bus.dout   = s1_q;
            assign bus.rd_vld = s1_vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_gowin_sp_param.sv
// Directed bench: four RAM instances in different modes share one input bus,
// each with its own hand-computed expected outputs.
module tb_gowin_sp_param;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 8;
    localparam int NL = DW / LW;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ce    = 1'b0;
    logic          oce   = 1'b0;
    logic          wre   = 1'b0;
    logic [NL-1:0] be    = '0;
    logic [AW-1:0] ad    = '0;
    logic [DW-1:0] din   = '0;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    gowin_sp_param_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) ifA ();
    gowin_sp_param_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) ifB ();
    gowin_sp_param_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) ifC ();
    gowin_sp_param_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) ifD ();

    assign ifA.ce = ce; assign ifA.oce = oce; assign ifA.wre = wre;
    assign ifA.be = be; assign ifA.ad = ad; assign ifA.din = din;
    assign ifB.ce = ce; assign ifB.oce = oce; assign ifB.wre = wre;
    assign ifB.be = be; assign ifB.ad = ad; assign ifB.din = din;
    assign ifC.ce = ce; assign ifC.oce = oce; assign ifC.wre = wre;
    assign ifC.be = be; assign ifC.ad = ad; assign ifC.din = din;
    assign ifD.ce = ce; assign ifD.oce = oce; assign ifD.wre = wre;
    assign ifD.be = be; assign ifD.ad = ad; assign ifD.din = din;

    // A: bypass read, read-before-write. B: pipelined read, write-through.
    // C: bypass read, normal write. D: like C but without the post-reset clear.
    gowin_sp_param #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .READ_MODE(0), .WRITE_MODE(2), .CLEAR_INIT(1))
        dutA (.clk(clk), .reset(reset), .bus(ifA));
    gowin_sp_param #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .READ_MODE(1), .WRITE_MODE(1), .CLEAR_INIT(1))
        dutB (.clk(clk), .reset(reset), .bus(ifB));
    gowin_sp_param #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_INIT(1))
        dutC (.clk(clk), .reset(reset), .bus(ifC));
    gowin_sp_param #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_INIT(0))
        dutD (.clk(clk), .reset(reset), .bus(ifD));

    typedef struct {
        logic          ceV;
        logic          wreV;
        logic          oceV;
        logic [NL-1:0] beV;
        logic [AW-1:0] adV;
        logic [DW-1:0] dinV;
        logic [DW-1:0] aDout;
        logic          aVld;
        logic [DW-1:0] bDout;
        logic          bVld;
        logic [DW-1:0] cDout;
        logic          cVld;
        logic          chkD;
    } vec_t;

    vec_t vecs [18];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ce  = v.ceV;
        wre = v.wreV;
        oce = v.oceV;
        be  = v.beV;
        ad  = v.adV;
        din = v.dinV;
    endtask

    function automatic logic [31:0] expWord(input int i, input bit usePat);
        logic [7:0] b;
        b = 8'(i);
        return usePat ? {b, ~b, 8'h5A, b + 8'd1} : 32'h0;
    endfunction

    // Counts cycles with busy high, starting from the current sample, bounded at 40.
    task automatic waitClear(output int busyCycles, output int vldSeen);
        busyCycles = 0;
        vldSeen    = 0;
        if (ifA.busy) busyCycles++;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (!ifA.busy) break;
            busyCycles++;
            vldSeen += int'(ifA.rd_vld) + int'(ifB.rd_vld) + int'(ifC.rd_vld);
        end
    endtask

    task automatic streamRead(input bit usePat);
        int aPulses;
        int bPulses;
        aPulses = 0;
        bPulses = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                ce = 1'b1; wre = 1'b0; oce = 1'b1; be = '1; ad = 4'(i);
            end else begin
                ce = 1'b0;
            end
            cycle();
            aPulses += int'(ifA.rd_vld);
            if (i < 16) begin
                checkOutput($sformatf("stream A @%0d", i), ifA.dout, expWord(i, usePat));
                checkOutput($sformatf("stream C @%0d", i), ifC.dout, expWord(i, usePat));
                if (usePat) checkOutput($sformatf("stream D @%0d", i), ifD.dout, expWord(i, usePat));
            end
            if (i >= 1) begin
                bPulses += int'(ifB.rd_vld);
                checkOutput($sformatf("stream B @%0d", i - 1), ifB.dout, expWord(i - 1, usePat));
            end
        end
        checkOutput("stream A pulses", 32'(aPulses), 32'd16);
        checkOutput("stream B pulses", 32'(bPulses), 32'd16);
    endtask

    initial begin
        int busyCycles;
        int vldSeen;

        //          ce wre oce be       ad     din            aDout          aV  bDout          bV  cDout          cV  chkD
        vecs[0]  = '{1, 1, 1, 4'hF,    4'd5, 32'h11223344, 32'h00000000, 1, 32'h00000000, 0, 32'h00000000, 0, 0};
        vecs[1]  = '{1, 1, 1, 4'b0101, 4'd5, 32'hAABBCCDD, 32'h11223344, 1, 32'h11223344, 1, 32'h00000000, 0, 0};
        vecs[2]  = '{1, 0, 1, 4'hF,    4'd5, 32'h00000000, 32'h11BB33DD, 1, 32'h11BB33DD, 1, 32'h11BB33DD, 1, 1};
        vecs[3]  = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h11BB33DD, 0, 32'h11BB33DD, 1, 32'h11BB33DD, 0, 0};
        vecs[4]  = '{1, 1, 1, 4'hF,    4'd3, 32'h00000055, 32'h00000000, 1, 32'h11BB33DD, 0, 32'h11BB33DD, 0, 0};
        vecs[5]  = '{1, 1, 1, 4'hF,    4'd3, 32'h00000066, 32'h00000055, 1, 32'h00000055, 1, 32'h11BB33DD, 0, 0};
        vecs[6]  = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h00000055, 0, 32'h00000066, 1, 32'h11BB33DD, 0, 0};
        vecs[7]  = '{1, 1, 1, 4'hF,    4'd1, 32'h000000A1, 32'h00000000, 1, 32'h00000066, 0, 32'h11BB33DD, 0, 0};
        vecs[8]  = '{1, 1, 1, 4'hF,    4'd2, 32'h000000A2, 32'h00000000, 1, 32'h000000A1, 1, 32'h11BB33DD, 0, 0};
        vecs[9]  = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h00000000, 0, 32'h000000A2, 1, 32'h11BB33DD, 0, 0};
        vecs[10] = '{1, 0, 1, 4'hF,    4'd3, 32'h00000000, 32'h00000066, 1, 32'h000000A2, 0, 32'h00000066, 1, 1};
        vecs[11] = '{1, 0, 1, 4'hF,    4'd1, 32'h00000000, 32'h000000A1, 1, 32'h00000066, 1, 32'h000000A1, 1, 1};
        vecs[12] = '{1, 0, 0, 4'hF,    4'd2, 32'h00000000, 32'h000000A2, 1, 32'h00000066, 0, 32'h000000A2, 1, 1};
        vecs[13] = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h000000A2, 0, 32'h000000A2, 1, 32'h000000A2, 0, 0};
        vecs[14] = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h000000A2, 0, 32'h000000A2, 0, 32'h000000A2, 0, 0};
        vecs[15] = '{1, 1, 1, 4'h0,    4'd5, 32'hFFFFFFFF, 32'h11BB33DD, 1, 32'h000000A2, 0, 32'h000000A2, 0, 0};
        vecs[16] = '{1, 0, 1, 4'hF,    4'd5, 32'h00000000, 32'h11BB33DD, 1, 32'h11BB33DD, 1, 32'h11BB33DD, 1, 1};
        vecs[17] = '{0, 0, 1, 4'hF,    4'd0, 32'h00000000, 32'h11BB33DD, 0, 32'h11BB33DD, 1, 32'h11BB33DD, 0, 0};

        // Reset state and the initial clear.
        cycle();
        cycle();
        checkOutput("reset busy A", 32'(ifA.busy), 32'd1);
        checkOutput("reset dout A", ifA.dout, 32'h0);
        checkOutput("reset vld A", 32'(ifA.rd_vld), 32'd0);
        checkOutput("reset dout B", ifB.dout, 32'h0);
        checkOutput("reset vld B", 32'(ifB.rd_vld), 32'd0);
        checkOutput("reset busy D", 32'(ifD.busy), 32'd0);
        reset = 1'b0;
        waitClear(busyCycles, vldSeen);
        checkOutput("clear cycles", 32'(busyCycles), 32'd16);
        checkOutput("clear busy B", 32'(ifB.busy), 32'd0);

        streamRead(1'b0);

        // Lane writes, write modes and oce gating.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            cycle();
            checkOutput($sformatf("row%0d dout A", i), ifA.dout, vecs[i].aDout);
            checkOutput($sformatf("row%0d vld A", i), 32'(ifA.rd_vld), 32'(vecs[i].aVld));
            checkOutput($sformatf("row%0d dout B", i), ifB.dout, vecs[i].bDout);
            checkOutput($sformatf("row%0d vld B", i), 32'(ifB.rd_vld), 32'(vecs[i].bVld));
            checkOutput($sformatf("row%0d dout C", i), ifC.dout, vecs[i].cDout);
            checkOutput($sformatf("row%0d vld C", i), 32'(ifC.rd_vld), 32'(vecs[i].cVld));
            if (vecs[i].chkD) begin
                checkOutput($sformatf("row%0d dout D", i), ifD.dout, vecs[i].cDout);
                checkOutput($sformatf("row%0d vld D", i), 32'(ifD.rd_vld), 32'd1);
            end
        end

        // Reset in the middle of a clear, with writes attempted while busy.
        ce = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        ce = 1'b1; wre = 1'b1; be = '1; ad = 4'd5; din = 32'hDEADBEEF;
        for (int k = 0; k < 7; k++) cycle();
        checkOutput("mid-clear busy", 32'(ifA.busy), 32'd1);
        reset = 1'b1;
        cycle();
        checkOutput("mid-clear reset dout A", ifA.dout, 32'h0);
        reset = 1'b0;
        waitClear(busyCycles, vldSeen);
        checkOutput("restart clear cycles", 32'(busyCycles), 32'd16);
        checkOutput("vld while busy", 32'(vldSeen), 32'd0);
        ce = 1'b1; wre = 1'b0; oce = 1'b1; ad = 4'd5;
        cycle();
        checkOutput("dropped write A", ifA.dout, 32'h0);
        checkOutput("dropped write vld A", 32'(ifA.rd_vld), 32'd1);
        checkOutput("accepted write D", ifD.dout, 32'hDEADBEEF);
        ce = 1'b0;
        cycle();
        checkOutput("dropped write B", ifB.dout, 32'h0);
        checkOutput("dropped write vld B", 32'(ifB.rd_vld), 32'd1);

        // Fill with a pattern, then stream it back.
        for (int i = 0; i < 16; i++) begin
            ce = 1'b1; wre = 1'b1; be = '1; ad = 4'(i); din = expWord(i, 1'b1);
            cycle();
        end
        streamRead(1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
